gated_d_latch: RTL and testbench



---
 rtl/gated_d_latch_if.sv | 21 ++
 rtl/gated_d_latch.sv | 33 +++
 tb/tb_gated_d_latch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gated_d_latch_if.sv
// Data bundle of the gated D latch: data input a, latched output s1 and its
// complement s2. The master drives a, the slave (latch) drives s1/s2.
interface gated_d_latch_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    modport master (
        output a,
        input  s1,
        input  s2
    );

    modport slave (
        input  a,
        output s1,
        output s2
    );
endinterface

// File: rtl/gated_d_latch.sv
// Level-sensitive gated D latch: transparent while clk is high, holding while
// clk is low, with a clock-qualified reset and a complementary output.
module gated_d_latch #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    gated_d_latch_if.slave  bus
);

    logic [WIDTH-1:0] s1_d;
    logic [WIDTH-1:0] s1_q;

    // Reset outranks the data path whenever the latch is open.
    always_comb begin
        s1_d = bus.a;
        if (rst) begin
            s1_d = RESET_VALUE;
        end
    end

    always_latch begin
        if (clk) begin
            s1_q <= s1_d;
        end
    end

    // s2 comes straight from the stored value, so it can never lag s1.
    assign bus.s1 = s1_q;
    assign bus.s2 = ~s1_q;

endmodule

// File: tb/tb_gated_d_latch.sv
// Directed bench for an 8-bit gated_d_latch: a behavioural latch model pushes
// expected outputs into a queue as stimulus is applied; checks pop and compare.
module tb_gated_d_latch;

    localparam int               W  = 8;
    localparam logic [W-1:0]     RV = 8'h00;

    typedef struct {
        logic [W-1:0] s1;
        string        tag;
    } expect_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] modelQ;
    logic [W-1:0] aval;
    expect_t      scoreboard[$];
    int           checks;
    int           errors;

    gated_d_latch_if #(.WIDTH(W)) bus ();

    gated_d_latch #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive one set of levels and record what an ideal latch would show.
    task automatic applyStimulus(input logic c, input logic r,
                                 input logic [W-1:0] av, input string tag);
        expect_t e;
        clk    = c;
        rst    = r;
        bus.a  = av;
        if (c) begin
            modelQ = r ? RV : av;
        end
        e.s1  = modelQ;
        e.tag = tag;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = scoreboard.pop_front();
            checks++;
            assert (bus.s1 === e.s1) else begin
                errors++;
                $error("FAIL %s_s1 observed=%h expected=%h", e.tag, bus.s1, e.s1);
            end
            checks++;
            assert (bus.s2 === ~e.s1) else begin
                errors++;
                $error("FAIL %s_s2 observed=%h expected=%h", e.tag, bus.s2, ~e.s1);
            end
        end
    endtask

    task automatic step(input logic c, input logic r,
                        input logic [W-1:0] av, input string tag);
        applyStimulus(c, r, av, tag);
        #1;
        checkOutput();
        #9;
    endtask

    // One 100-unit clock phase, checked just after the change and mid-phase.
    task automatic phase(input logic c, input logic [W-1:0] av, input string tag);
        applyStimulus(c, 1'b0, av, tag);
        #1;
        checkOutput();
        #49;
        applyStimulus(c, 1'b0, av, {tag, "_mid"});
        #1;
        checkOutput();
        #49;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst    = 1'b0;
        bus.a  = '0;
        #10;

        // Basic transparency
        step(1'b1, 1'b0, 8'h00, "transp_a0");
        step(1'b1, 1'b0, 8'hFF, "transp_a1");

        // Hold: a toggles while clk is low
        step(1'b0, 1'b0, 8'hFF, "hold_fall");
        step(1'b0, 1'b0, 8'h00, "hold_a0");
        step(1'b0, 1'b0, 8'hFF, "hold_a1");
        step(1'b0, 1'b0, 8'h12, "hold_a2");

        // Clocked pattern: 7 rising edges, a toggles every second rising edge
        aval = 8'h0F;
        for (int e = 0; e < 7; e++) begin
            if (e % 2 == 0) begin
                aval = ~aval;
            end
            phase(1'b1, aval, "pat_hi");
            phase(1'b0, aval, "pat_lo");
        end

        // Reset during transparency, then release with clk still high
        step(1'b0, 1'b0, 8'hFF, "rst_prep");
        step(1'b1, 1'b1, 8'hFF, "rst_transp");
        step(1'b1, 1'b1, 8'h77, "rst_a_change");
        step(1'b1, 1'b0, 8'h77, "rst_release");
        step(1'b1, 1'b0, 8'hFF, "rst_follow");

        // Reset ignored while opaque
        step(1'b0, 1'b0, 8'hFF, "opq_capture");
        step(1'b0, 1'b1, 8'hFF, "opq_rst_hi");
        step(1'b0, 1'b0, 8'hFF, "opq_rst_lo");
        step(1'b1, 1'b0, 8'hFF, "opq_reopen");

        // clk falls while rst high: reset value is held
        step(1'b1, 1'b1, 8'hFF, "rstfall_hi");
        step(1'b0, 1'b1, 8'hFF, "rstfall_lo");
        step(1'b0, 1'b0, 8'hFF, "rstfall_hold");
        step(1'b1, 1'b0, 8'hFF, "rstfall_reopen");

        // Width / per-bit independence
        step(1'b1, 1'b0, 8'hA5, "wid_open");
        step(1'b0, 1'b0, 8'hA5, "wid_capture");
        step(1'b0, 1'b0, 8'h3C, "wid_hold");
        step(1'b1, 1'b0, 8'h3C, "wid_next");
        step(1'b1, 1'b0, 8'h81, "wid_follow");

        if (scoreboard.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0", scoreboard.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
